// File: rtl/spi_xfer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_xfer_seq
// Purpose  : Transaction sequencer in front of spi_core. Accepts one transfer
//            descriptor at a time and loads the core frame counter. It owns
//            the active-low chip selects and times CS setup, st start/stop,
//            CS hold and the inter-transfer gap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            in   clock
//   rst_n_i          in   asynchronous active-low reset
//   req_valid_i      in   descriptor valid
//   req_ready_o      out  descriptor accepted when valid && ready (idle only)
//   req_cs_i         in   target chip-select index
//   req_rwm_i        in   1 = read after cmd/addr, 0 = write only
//   req_trl_i        in   frames in transfer minus 1
//   req_cal_i        in   frame-count threshold for cmd/addr phase
//   abort_i          in   terminate current transfer
//   core_st_o        out  spi_core start
//   core_trl_valid_o out  spi_core frame-count load strobe
//   core_trl_o       out  spi_core frame count
//   core_cal_o       out  spi_core cmd/addr threshold, held until next accept
//   core_rwm_o       out  spi_core rw mode, held until next accept
//   core_busy_i      in   spi_core busy
//   core_last_i      in   spi_core last frame
//   nss_o            out  active-low chip selects, at most one low
//   busy_o           out  sequencer not idle
//   done_o           out  1-cycle pulse on transfer completion
//   aborted_o        out  1-cycle pulse with done_o when the transfer aborted
// ============================================================================
module spi_xfer_seq #(
  parameter int CS_NUM    = 4,
  parameter int TRL_WIDTH = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [$clog2(CS_NUM)-1:0] req_cs_i,
  input  logic                      req_rwm_i,
  input  logic [TRL_WIDTH-1:0]      req_trl_i,
  input  logic [TRL_WIDTH-1:0]      req_cal_i,
  input  logic                      abort_i,
  output logic                      core_st_o,
  output logic                      core_trl_valid_o,
  output logic [TRL_WIDTH-1:0]      core_trl_o,
  output logic [TRL_WIDTH-1:0]      core_cal_o,
  output logic                      core_rwm_o,
  input  logic                      core_busy_i,
  input  logic                      core_last_i,
  output logic [CS_NUM-1:0]         nss_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o
);

  localparam int CS_W    = $clog2(CS_NUM);
  localparam int MAX_A   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counters are loaded with N-1 on state entry so each timed state lasts
  // exactly N cycles; the exit fires when the count reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_XFER  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CS_NUM-1:0]      nss_q, nss_d;
  logic [TRL_WIDTH-1:0]   trl_q, trl_d;
  logic [TRL_WIDTH-1:0]   cal_q, cal_d;
  logic                   rwm_q, rwm_d;
  logic                   st_q, st_d;
  logic                   seen_busy_q, seen_busy_d;
  logic                   abort_q, abort_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   abort_hit;
  logic [CS_NUM-1:0]      cs_dec;

  // An out-of-range index matches no bit, so no chip select is asserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (req_cs_i == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nss_q       <= '1;
      trl_q       <= '0;
      cal_q       <= '0;
      rwm_q       <= 1'b0;
      st_q        <= 1'b0;
      seen_busy_q <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nss_q       <= nss_d;
      trl_q       <= trl_d;
      cal_q       <= cal_d;
      rwm_q       <= rwm_d;
      st_q        <= st_d;
      seen_busy_q <= seen_busy_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nss_d       = nss_q;
    trl_d       = trl_q;
    cal_d       = cal_q;
    rwm_d       = rwm_q;
    st_d        = st_q;
    seen_busy_d = seen_busy_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    abort_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_LOAD;
          nss_d   = cs_dec;
          trl_d   = req_trl_i;
          cal_d   = req_cal_i;
          rwm_d   = req_rwm_i;
          abort_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          abort_hit = 1'b1;
        end else begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (abort_i) begin
          abort_hit = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = S_XFER;
          st_d        = 1'b1;
          seen_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_XFER: begin
        // last is only trusted once the core has reported busy for this
        // transfer; before that it may reflect the previous frame count.
        if (abort_i) begin
          abort_hit = 1'b1;
        end else if (seen_busy_q && core_last_i) begin
          state_d = S_HOLD;
          st_d    = 1'b0;
          cnt_d   = HOLD_LD;
        end else if (core_busy_i) begin
          seen_busy_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LD;
          nss_d     = '1;
          done_d    = 1'b1;
          aborted_d = abort_q;
          abort_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_hit) begin
      state_d = S_HOLD;
      st_d    = 1'b0;
      cnt_d   = HOLD_LD;
      abort_d = 1'b1;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign core_trl_valid_o = (state_q == S_LOAD);
  assign core_trl_o       = trl_q;
  assign core_cal_o       = cal_q;
  assign core_rwm_o       = rwm_q;
  assign core_st_o        = st_q;
  assign nss_o            = nss_q;
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_seq
// Purpose  : Self-checking bench for spi_xfer_seq. Each transfer is described
//            by when the bench drives busy/last/abort relative to the accept;
//            expected outputs per cycle follow from those times with plain
//            arithmetic (setup, hold and gap lengths).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_seq;

  localparam int CS_NUM = 4;
  localparam int TRLW   = 8;
  localparam int SETUP  = 2;
  localparam int HOLD   = 2;
  localparam int GAP    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_cs = '0;
  logic            req_rwm = 1'b0;
  logic [TRLW-1:0] req_trl = '0;
  logic [TRLW-1:0] req_cal = '0;
  logic            abort = 1'b0;
  logic            core_st;
  logic            core_trl_valid;
  logic [TRLW-1:0] core_trl;
  logic [TRLW-1:0] core_cal;
  logic            core_rwm;
  logic            core_busy = 1'b0;
  logic            core_last = 1'b0;
  logic [3:0]      nss;
  logic            busy;
  logic            done;
  logic            aborted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_xfer_seq #(
    .CS_NUM(CS_NUM), .TRL_WIDTH(TRLW), .SETUP_CYC(SETUP),
    .HOLD_CYC(HOLD), .GAP_CYC(GAP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cs_i(req_cs), .req_rwm_i(req_rwm), .req_trl_i(req_trl), .req_cal_i(req_cal),
    .abort_i(abort),
    .core_st_o(core_st), .core_trl_valid_o(core_trl_valid), .core_trl_o(core_trl),
    .core_cal_o(core_cal), .core_rwm_o(core_rwm),
    .core_busy_i(core_busy), .core_last_i(core_last),
    .nss_o(nss), .busy_o(busy), .done_o(done), .aborted_o(aborted)
  );

  // Transfer description: kb = cycle (after accept) the bench starts driving
  // busy, kl = cycle it drives last, ka = cycle it drives abort (if ab).
  typedef struct {
    logic [1:0]      cs;
    logic            rwm;
    logic [TRLW-1:0] trl;
    logic [TRLW-1:0] cal;
    bit              stale;
    bit              ab;
    int              kb;
    int              kl;
    int              ka;
  } desc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic desc_t mk(input logic [1:0] cs, input logic rwm, input logic [7:0] trl,
                               input logic [7:0] cal, input bit stale, input bit ab,
                               input int kb, input int kl, input int ka);
    desc_t d;
    d.cs = cs; d.rwm = rwm; d.trl = trl; d.cal = cal;
    d.stale = stale; d.ab = ab; d.kb = kb; d.kl = kl; d.ka = ka;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.cs    = 2'($urandom_range(0, 3));
    d.rwm   = 1'($urandom_range(0, 1));
    d.trl   = 8'($urandom_range(0, 255));
    d.cal   = 8'($urandom_range(0, 255));
    d.stale = ($urandom_range(0, 3) == 0);
    d.ab    = ($urandom_range(0, 3) == 0);
    d.kb    = SETUP + 1 + (d.stale ? 3 : 0) + int'($urandom_range(0, 3));
    d.kl    = d.kb + 1 + int'($urandom_range(0, 4));
    d.ka    = int'($urandom_range(0, 1000)) % d.kl;
    return d;
  endfunction

  // Called just after a falling edge. Presents d, waits for the accept,
  // then checks every cycle until the sequencer would return to idle.
  task automatic run(input desc_t d, input bit chained);
    int         n;
    int         stop;
    int         end_k;
    logic [3:0] nss_exp;
    req_cs    = d.cs;
    req_rwm   = d.rwm;
    req_trl   = d.trl;
    req_cal   = d.cal;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    // A queued descriptor is taken on the first idle cycle after the gap.
    if (chained) chk("b2b_wait", n, 1);
    @(negedge clk);
    stop    = d.ab ? d.ka + 1 : d.kl + 1;
    end_k   = stop + HOLD;
    nss_exp = 4'hF & ~(4'b0001 << d.cs);
    for (int k = 0; k < end_k + GAP; k++) begin
      chk("nss", nss, (k < end_k) ? nss_exp : 4'hF);
      chk("trl_valid", core_trl_valid, 32'(k == 0));
      if (k == 0) chk("trl", core_trl, d.trl);
      chk("st", core_st, 32'(k >= SETUP + 1 && k < stop));
      chk("done", done, 32'(k == end_k));
      chk("aborted", aborted, 32'(d.ab && k == end_k));
      chk("busy", busy, 1);
      chk("ready", req_ready, 0);
      chk("cal", core_cal, d.cal);
      chk("rwm", core_rwm, d.rwm);
      req_valid = 1'b0;
      core_last = (d.stale && k <= SETUP + 3) || (!d.ab && k == d.kl);
      core_busy = (k >= d.kb && k < stop);
      abort     = d.ab && (k == d.ka);
      if (k < end_k + GAP - 1) @(negedge clk);
    end
    core_last = 1'b0;
    core_busy = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic idle(input int m);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      chk("idle_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_nss", nss, 4'hF);
      chk("idle_done", done, 0);
      chk("idle_st", core_st, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ch;
    desc_t d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_nss", nss, 4'hF);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_st", core_st, 0);
    chk("rst_trl_valid", core_trl_valid, 0);
    chk("rst_trl", core_trl, 0);
    chk("rst_cal", core_cal, 0);
    chk("rst_rwm", core_rwm, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    rst_n = 1'b1;
    idle(2);

    // Write to cs 2
    run(mk(2'd2, 1'b0, 8'd3, 8'd0, 0, 0, SETUP + 1, SETUP + 4, 0), 0);
    idle(2);
    // Read from cs 0
    run(mk(2'd0, 1'b1, 8'd5, 8'd1, 0, 0, SETUP + 1, SETUP + 6, 0), 0);
    idle(2);
    // Abort four cycles into XFER
    run(mk(2'd1, 1'b0, 8'd7, 8'd2, 0, 1, SETUP + 1, SETUP + 10, SETUP + 4), 0);
    idle(1);
    // Abort while still in LOAD
    run(mk(2'd3, 1'b1, 8'd9, 8'd4, 0, 1, SETUP + 1, SETUP + 5, 0), 0);
    idle(1);
    // Back-to-back queued descriptors
    run(mk(2'd1, 1'b1, 8'd2, 8'd1, 0, 0, SETUP + 1, SETUP + 3, 0), 0);
    run(mk(2'd3, 1'b0, 8'd4, 8'd0, 0, 0, SETUP + 2, SETUP + 4, 0), 1);
    idle(1);
    // Stale last at XFER entry
    run(mk(2'd3, 1'b0, 8'd6, 8'd3, 1, 0, SETUP + 5, SETUP + 7, 0), 0);
    idle(1);

    // Randomised transfers, some queued back-to-back
    ch = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d = rand_desc();
      run(d, ch);
      ch = 1'($urandom_range(0, 1));
      if (!ch) idle(1 + int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of XFER
    req_cs = 2'd1; req_rwm = 1'b1; req_trl = 8'd8; req_cal = 8'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (SETUP + 2) @(negedge clk);
    chk("pre_rst_st", core_st, 1);
    chk("pre_rst_nss", nss, 4'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("async_nss", nss, 4'hF);
    chk("async_st", core_st, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 1);
    chk("async_cal", core_cal, 0);
    chk("async_rwm", core_rwm, 0);
    @(negedge clk);
    chk("async_done", done, 0);
    rst_n = 1'b1;
    idle(3);
    run(mk(2'd2, 1'b1, 8'd1, 8'd1, 0, 0, SETUP + 1, SETUP + 2, 0), 0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
